// File: rtl/handshake_fifo_if.sv
// Valid/ready handshake bundle for handshake_fifo: upstream push side, downstream pop side,
// and occupancy status.
interface handshake_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic              d_valid_i;
    logic [DATA_W-1:0] d_data_i;
    logic              d_ready_o;
    logic              s_valid_o;
    logic [DATA_W-1:0] s_data_o;
    logic              s_ready_i;
    logic [AW:0]       count_o;
    logic              full_o;
    logic              empty_o;

    modport master (
        output d_valid_i, d_data_i, s_ready_i,
        input  d_ready_o, s_valid_o, s_data_o, count_o, full_o, empty_o
    );

    modport slave (
        input  d_valid_i, d_data_i, s_ready_i,
        output d_ready_o, s_valid_o, s_data_o, count_o, full_o, empty_o
    );
endinterface

// File: rtl/handshake_fifo.sv
// First-word fall-through FIFO with valid/ready on both sides; ready and valid are
// derived from registered occupancy only, so neither side sees a combinational path.
module handshake_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    handshake_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // d_ready_o is gated by rst, so no push can land on a reset edge.
    assign bus.d_ready_o = ~full & ~rst;
    assign bus.s_valid_o = ~empty;
    assign bus.s_data_o  = empty ? '0 : mem[rd_ptr];
    assign bus.count_o   = count;
    assign bus.full_o    = full;
    assign bus.empty_o   = empty;

    assign push = bus.d_valid_i & bus.d_ready_o;
    assign pop  = bus.s_valid_o & bus.s_ready_i & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // Storage is never reset; the empty mux on s_data_o hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.d_data_i;
        end
    end
endmodule

// File: tb/tb_handshake_fifo.sv
// Bench for handshake_fifo (DATA_W=8, DEPTH=4): per-cycle vector table with post-edge
// expectations, plus a queue scoreboard that tracks occupancy and FIFO order.
module tb_handshake_fifo;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    handshake_fifo_if #(.DATA_W(8), .DEPTH(4)) bus ();

    handshake_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       r;
        logic       dv;
        logic [7:0] dd;
        logic       sr;
        int         e_cnt;
        logic       e_sv;
        logic [7:0] e_dat;
        logic       e_full;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] sb[$];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic dv, input logic [7:0] dd, input logic sr,
                       input int e_cnt, input logic e_sv, input logic [7:0] e_dat,
                       input logic e_full);
        vec_t v;
        v.r = r; v.dv = dv; v.dd = dd; v.sr = sr;
        v.e_cnt = e_cnt; v.e_sv = e_sv; v.e_dat = e_dat; v.e_full = e_full;
        vq.push_back(v);
    endtask

    // Drive one cycle; pre-edge outputs are checked against the scoreboard queue.
    task automatic cycle(input logic r, input logic dv, input logic [7:0] dd, input logic sr);
        bit will_push;
        bit will_pop;
        rst           = r;
        bus.d_valid_i = dv;
        bus.d_data_i  = dd;
        bus.s_ready_i = sr;
        #1;
        will_pop  = !r && sr && (sb.size() != 0);
        will_push = !r && dv && (sb.size() < 4);
        chk("d_ready", int'(bus.d_ready_o), int'(!r && sb.size() < 4));
        chk("s_valid", int'(bus.s_valid_o), int'(sb.size() != 0));
        chk("count", int'(bus.count_o), sb.size());
        chk("empty", int'(bus.empty_o), int'(sb.size() == 0));
        chk("full", int'(bus.full_o), int'(sb.size() == 4));
        if (sb.size() != 0) chk("head_data", int'(bus.s_data_o), int'(sb[0]));
        else                chk("idle_data", int'(bus.s_data_o), 0);
        @(posedge clk);
        if (r) begin
            sb.delete();
        end else begin
            if (will_pop)  void'(sb.pop_front());
            if (will_push) sb.push_back(dd);
        end
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.d_valid_i = 1'b0;
        bus.d_data_i  = '0;
        bus.s_ready_i = 1'b0;
        @(posedge clk);
        #1;

        // reset state, then single word held under backpressure
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        add(0, 1, 8'hA5, 0, 1, 1, 8'hA5, 0);
        add(0, 0, 8'h00, 0, 1, 1, 8'hA5, 0);
        add(0, 0, 8'h00, 0, 1, 1, 8'hA5, 0);
        add(0, 0, 8'h00, 0, 1, 1, 8'hA5, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        // fill to full, 0x05 held upstream
        add(0, 1, 8'h01, 0, 1, 1, 8'h01, 0);
        add(0, 1, 8'h02, 0, 2, 1, 8'h01, 0);
        add(0, 1, 8'h03, 0, 3, 1, 8'h01, 0);
        add(0, 1, 8'h04, 0, 4, 1, 8'h01, 1);
        add(0, 1, 8'h05, 0, 4, 1, 8'h01, 1);
        add(0, 1, 8'h05, 0, 4, 1, 8'h01, 1);
        // pop from full: no push on that edge, 0x05 enters next cycle
        add(0, 1, 8'h05, 1, 3, 1, 8'h02, 0);
        add(0, 1, 8'h05, 1, 3, 1, 8'h03, 0);
        add(0, 0, 8'h00, 1, 2, 1, 8'h04, 0);
        add(0, 0, 8'h00, 1, 1, 1, 8'h05, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        // reset with three stored words
        add(0, 1, 8'h31, 0, 1, 1, 8'h31, 0);
        add(0, 1, 8'h32, 0, 2, 1, 8'h31, 0);
        add(0, 1, 8'h33, 0, 3, 1, 8'h31, 0);
        add(1, 1, 8'h34, 1, 0, 0, 8'h00, 0);
        add(0, 1, 8'h7E, 0, 1, 1, 8'h7E, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        // pop attempts while empty
        for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);

        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].r, vq[i].dv, vq[i].dd, vq[i].sr);
            chk($sformatf("v%0d_count", i), int'(bus.count_o), vq[i].e_cnt);
            chk($sformatf("v%0d_s_valid", i), int'(bus.s_valid_o), int'(vq[i].e_sv));
            chk($sformatf("v%0d_s_data", i), int'(bus.s_data_o), int'(vq[i].e_dat));
            chk($sformatf("v%0d_full", i), int'(bus.full_o), int'(vq[i].e_full));
        end

        // streaming: one word per cycle, occupancy settles at 1, pointers wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
            chk($sformatf("stream%0d_count", i), int'(bus.count_o), 1);
            chk($sformatf("stream%0d_data", i), int'(bus.s_data_o), 16 + i);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("stream_drain_count", int'(bus.count_o), 0);
        chk("stream_drain_empty", int'(bus.empty_o), 1);

        // pointer consistency after wraps: a fresh push surfaces unchanged
        cycle(1'b0, 1'b1, 8'hC3, 1'b0);
        chk("post_wrap_data", int'(bus.s_data_o), 8'hC3);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_wrap_empty", int'(bus.empty_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/handshake_fifo.md
HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload width in bits (legal values 1 to 64).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of entries (power of 2, at least 2); AW = log2(DEPTH).
REQ-003 The block SHALL have port clk, input, width 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port d_valid_i, input, width 1, meaning the upstream stage has valid data.
REQ-006 The block SHALL have port d_data_i, input, width DATA_W, meaning the upstream payload.
REQ-007 The block SHALL have port d_ready_o, output, width 1, meaning the block can accept data this cycle.
REQ-008 The block SHALL have port s_valid_o, output, width 1, meaning the block presents valid data downstream.
REQ-009 The block SHALL have port s_data_o, output, width DATA_W, meaning the downstream payload.
REQ-010 The block SHALL have port s_ready_i, input, width 1, meaning the downstream stage accepts data.
REQ-011 The block SHALL have port count_o, output, width AW+1, meaning the current occupancy, 0 to DEPTH.
REQ-012 The block SHALL have ports full_o and empty_o, output, width 1 each, meaning count_o==DEPTH and count_o==0 respectively.

Function
REQ-013 Push SHALL occur on a clock edge where d_valid_i=1 and d_ready_o=1; d_data_i is then written at wr_ptr and wr_ptr advances by 1.
REQ-014 Pop SHALL occur on a clock edge where s_valid_o=1 and s_ready_i=1; rd_ptr then advances by 1.
REQ-015 wr_ptr and rd_ptr SHALL be AW bits wide and wrap from DEPTH-1 to 0 with no special case.
REQ-016 d_ready_o SHALL equal ~full_o and ~rst; it SHALL have no combinational path from s_ready_i or d_valid_i.
REQ-017 s_valid_o SHALL equal ~empty_o; it SHALL have no combinational path from d_valid_i or s_ready_i.
REQ-018 s_data_o SHALL equal mem[rd_ptr] when s_valid_o=1 (first-word fall-through), and SHALL be 0 when s_valid_o=0.
REQ-019 Latency SHALL be 1 cycle: data pushed at edge N is visible on s_data_o with s_valid_o=1 after edge N, provided the FIFO was empty.
REQ-020 count_o SHALL update per edge as follows: +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop or on neither.
REQ-021 Simultaneous push and pop SHALL be legal whenever 0<count_o<DEPTH; throughput SHALL then be 1 word per cycle.
REQ-022 When full, push SHALL be impossible even if a pop occurs in the same cycle; d_ready_o rises the cycle after the pop.
REQ-023 When empty, pop SHALL be impossible; a push into an empty FIFO SHALL not be bypassed to the output in the same cycle.
REQ-024 While s_valid_o=1 and s_ready_i=0, s_valid_o and s_data_o SHALL hold stable until a pop occurs.
REQ-025 Data order SHALL be strictly first-in first-out; no word SHALL be dropped, duplicated or reordered.

Reset
REQ-026 While rst=1 at an edge, wr_ptr, rd_ptr and count_o SHALL go to 0; after that edge s_valid_o=0, s_data_o=0, empty_o=1 and full_o=0.
REQ-027 d_ready_o SHALL be 0 while rst=1 and SHALL be 1 from the first cycle after rst deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all stored words; no push or pop SHALL take effect on an edge where rst=1.
REQ-029 Memory contents SHALL NOT require reset; stale entries SHALL never be visible because of REQ-018.

Verification (DATA_W=8, DEPTH=4)
REQ-030 Single word: the bench pushes 0xA5 into an empty FIFO with s_ready_i=0 -> the next cycle shows s_valid_o=1, s_data_o=0xA5, count_o=1, and these hold for 3 idle cycles.
REQ-031 Fill and backpressure: the bench pushes 0x01..0x05 back-to-back with s_ready_i=0 -> 0x01..0x04 are accepted, full_o=1, d_ready_o=0, count_o=4, and 0x05 is held upstream.
REQ-032 Full with pop: from full, the bench sets s_ready_i=1 with d_valid_i=1 -> no push on the pop edge, d_ready_o=1 the next cycle, and the output sequence is 0x01,0x02,0x03,0x04,0x05.
REQ-033 Streaming and wrap: the bench holds d_valid_i=1 and s_ready_i=1 for 10 cycles with data 0x10..0x19 -> one word per cycle, in order, count_o stays at 1, and the pointers wrap twice.
REQ-034 Reset mid-operation: the bench applies rst=1 for one edge with count_o=3 -> count_o=0, s_valid_o=0, s_data_o=0, d_ready_o=0 during reset, and the next push of 0x7E is output first.
REQ-035 Empty pop: the bench holds s_ready_i=1 while empty for 5 cycles -> s_valid_o=0, count_o=0 and no pointer change.
